// File: rtl/secuenciador_alu.sv
// secuenciador_alu: board front-end for the lab ALU.
//
// Debounces the five push buttons, latches operands A/B from the switches,
// steps the opcode and runs an execute sequence: operands are held for a
// settle window, then the external ALU's result and flags are captured.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sw[15:0]            sw[7:0] -> operand A, sw[15:8] -> operand B
//   push[4:0]           raw buttons: load A, load B, next op, execute, clear
//   alu_result/flags    combinational ALU outputs
//   num_a_out/num_b_out operands driven to the ALU
//   ALU_control         opcode driven to the ALU
//   result_out/flags_out, result_valid   captured result
//   busy, err, estado   EXEC indicator, sticky execute error, state code
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | editing operands/opcode, waiting for an execute press
// EXEC  | operands held stable for SETTLE cycles, busy high
// SHOW  | result captured and displayed, result_valid high
module secuenciador_alu #(
  parameter int DB_CYCLES = 4,
  parameter int SETTLE    = 2,
  parameter int N_OPS     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  push,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic [7:0]  num_a_out,
  output logic [7:0]  num_b_out,
  output logic [3:0]  ALU_control,
  output logic [7:0]  result_out,
  output logic [3:0]  flags_out,
  output logic        result_valid,
  output logic        busy,
  output logic        err,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_FULL = DBW'(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [STW-1:0] ST_LAST = STW'(SETTLE - 1);
  localparam logic [3:0] OP_LAST = 4'(N_OPS - 1);

  logic [4:0] btn_pulse;

  // One debouncer per button. While armed the counter measures a run of
  // high samples; once it reaches DB_CYCLES the button fires once and is
  // disarmed, and the same counter then measures a run of low samples
  // that must reach DB_CYCLES before the button can fire again.
  for (genvar g = 0; g < 5; g++) begin : g_db
    logic           sync_1;
    logic           sync_2;
    logic           armed;
    logic           pulse_q;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_1  <= 1'b0;
        sync_2  <= 1'b0;
        armed   <= 1'b1;
        pulse_q <= 1'b0;
        cnt     <= '0;
      end else begin
        sync_1  <= push[g];
        sync_2  <= sync_1;
        pulse_q <= 1'b0;
        if (armed) begin
          if (cnt == DB_FULL) begin
            pulse_q <= 1'b1;
            armed   <= 1'b0;
            cnt     <= '0;
          end else if (sync_2) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end else begin
          if (sync_2) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            armed <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end

    assign btn_pulse[g] = pulse_q;
  end

  logic ld_a, ld_b, nxt_op, exe, clr;
  assign ld_a   = btn_pulse[0];
  assign ld_b   = btn_pulse[1];
  assign nxt_op = btn_pulse[2];
  assign exe    = btn_pulse[3];
  assign clr    = btn_pulse[4];

  state_t         state, state_nxt;
  logic           a_loaded, b_loaded;
  logic [STW-1:0] settle_cnt;
  logic           exe_ok, settle_done, any_edit;

  // Loads arriving on the same edge as execute count toward readiness.
  assign exe_ok      = (a_loaded | ld_a) & (b_loaded | ld_b);
  assign settle_done = (settle_cnt == '0);
  assign any_edit    = ld_a | ld_b | nxt_op;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (exe && exe_ok)               state_nxt = EXEC;
          else if (state == SHOW && any_edit) state_nxt = IDLE;
        end
        EXEC:    if (settle_done) state_nxt = SHOW;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state == EXEC);
    estado = state;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      num_a_out    <= '0;
      num_b_out    <= '0;
      ALU_control  <= '0;
      result_out   <= '0;
      flags_out    <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      a_loaded     <= 1'b0;
      b_loaded     <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (ld_a) begin
            num_a_out <= sw[7:0];
            a_loaded  <= 1'b1;
          end
          if (ld_b) begin
            num_b_out <= sw[15:8];
            b_loaded  <= 1'b1;
          end
          if (nxt_op)
            ALU_control <= (ALU_control == OP_LAST) ? 4'd0 : ALU_control + 4'd1;
          if (any_edit || exe) err <= 1'b0;
          if (exe && !exe_ok) err <= 1'b1;
          if (exe && exe_ok) settle_cnt <= ST_LAST;
          if ((state == SHOW && any_edit) || (exe && exe_ok))
            result_valid <= 1'b0;
        end
        EXEC: begin
          if (settle_done) begin
            result_out   <= alu_result;
            flags_out    <= alu_flags;
            result_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_alu.sv
module tb_secuenciador_alu;
  localparam int DB   = 4;
  localparam int ST   = 2;
  localparam int NOPS = 10;
  // negedge (counted from the press) at which a steady press first shows
  localparam int EFFECT_J = DB + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  push;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;
  logic [7:0]  num_a_out, num_b_out, result_out;
  logic [3:0]  ALU_control, flags_out;
  logic        result_valid, busy, err;
  logic [1:0]  estado;
  logic [36:0] all_outs;

  always #5 clk = ~clk;

  secuenciador_alu #(.DB_CYCLES(DB), .SETTLE(ST), .N_OPS(NOPS)) dut (
    .clk(clk), .rst(rst), .sw(sw), .push(push),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .num_a_out(num_a_out), .num_b_out(num_b_out), .ALU_control(ALU_control),
    .result_out(result_out), .flags_out(flags_out), .result_valid(result_valid),
    .busy(busy), .err(err), .estado(estado)
  );

  assign all_outs = {num_a_out, num_b_out, ALU_control, result_out, flags_out,
                     result_valid, busy, err, estado};

  // external ALU stand-in
  logic       alu_fixed;
  logic [7:0] fix_res;
  logic [3:0] fix_flags;

  function automatic logic [11:0] alu_f(input logic fixed, input logic [7:0] fr,
                                        input logic [3:0] ff, input logic [7:0] a,
                                        input logic [7:0] b, input logic [3:0] op);
    logic [7:0] r;
    if (fixed) return {ff, fr};
    r = 8'(a + b) ^ {op, op};
    return {a[0] ^ b[0], r == 8'h00, r[7], op[0], r};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_fixed, fix_res, fix_flags,
                                         num_a_out, num_b_out, ALU_control);

  // transaction-level reference: effect of one completed press
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_op, m_flags;
  logic       m_ald, m_bld, m_err, m_valid, m_exec;
  logic [1:0] m_state;
  int n_checks = 0;
  int n_pass   = 0;
  bit pat[$];

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_flags = 0;
    m_ald = 0; m_bld = 0; m_err = 0; m_valid = 0; m_exec = 0; m_state = 0;
  endtask

  task automatic model_apply(input logic [4:0] m, input logic [15:0] swv);
    m_exec = 0;
    if (m[4]) begin
      model_reset();
      return;
    end
    if (m[0]) begin m_a = swv[7:0];  m_ald = 1; end
    if (m[1]) begin m_b = swv[15:8]; m_bld = 1; end
    if (m[2]) m_op = 4'((int'(m_op) + 1) % NOPS);
    if (m[3:0] != 4'b0) m_err = 0;
    if (m[3]) begin
      if (m_ald && m_bld) begin
        {m_flags, m_res} = alu_f(alu_fixed, fix_res, fix_flags, m_a, m_b, m_op);
        m_valid = 1; m_state = 2; m_exec = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_state == 2 && m[2:0] != 3'b0) begin
      m_valid = 0; m_state = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1; push = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // hold mask for 8 cycles, release for 12; reports busy cycles and the
  // negedge at which result_valid rose
  task automatic press(input logic [4:0] mask, output int busy_n, output int valid_j);
    logic prev;
    busy_n = 0; valid_j = -1; prev = result_valid;
    push = mask;
    for (int j = 1; j <= 20; j++) begin
      if (j == 9) push = '0;
      @(negedge clk);
      if (busy) busy_n++;
      if (result_valid && !prev && valid_j < 0) valid_j = j;
      prev = result_valid;
    end
    model_apply(mask, sw);
  endtask

  // drive pat[] on one load button, checking the operand every cycle
  task automatic run_pattern(input int btn);
    int run, jeff;
    logic [7:0] old_v, new_v, exp_v, got;
    logic [15:0] sw0;
    sw0 = sw;
    old_v = (btn == 0) ? m_a : m_b;
    new_v = (btn == 0) ? sw0[7:0] : sw0[15:8];
    run = 0; jeff = -1;
    foreach (pat[n]) begin
      run = pat[n] ? run + 1 : 0;
      if (run == DB && jeff < 0) jeff = n + 5;
    end
    for (int n = 0; n < pat.size(); n++) begin
      push = '0;
      push[btn] = pat[n];
      if (jeff >= 0 && n >= jeff) sw = ~sw0;
      @(negedge clk);
      got = (btn == 0) ? num_a_out : num_b_out;
      exp_v = (jeff >= 0 && n + 1 >= jeff) ? new_v : old_v;
      n_checks++;
      if (got !== exp_v)
        $display("FAIL pattern btn%0d cycle %0d: got %h expected %h", btn, n + 1, got, exp_v);
      else n_pass++;
    end
    push = '0;
    sw = sw0;
    if (jeff >= 0) model_apply(5'(1 << btn), sw0);
  endtask

  task automatic test_reset();
    rst = 1; push = '0; sw = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs !== 37'h0) $display("FAIL reset_outs: got %h expected 0", all_outs);
    else n_pass++;
    rst = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== 37'h0) $display("FAIL post_reset_outs: got %h expected 0", all_outs);
    else n_pass++;
    model_reset();
  endtask

  task automatic test_load_ab();
    sw = 16'h3C05;
    pat.delete();
    for (int k = 0; k < 8; k++)  pat.push_back(1'b1);
    for (int k = 0; k < 12; k++) pat.push_back(1'b0);
    run_pattern(0);
    run_pattern(1);
    n_checks++;
    if (num_a_out !== 8'h05) $display("FAIL load_a: got %h expected 05", num_a_out);
    else n_pass++;
    n_checks++;
    if (num_b_out !== 8'h3C) $display("FAIL load_b: got %h expected 3c", num_b_out);
    else n_pass++;
  endtask

  task automatic test_bounce();
    bit bounce[5] = '{1, 0, 1, 1, 0};
    sw = 16'($urandom);
    sw[7:0] = m_a ^ 8'($urandom_range(1, 255));
    pat.delete();
    foreach (bounce[k]) pat.push_back(bounce[k]);
    for (int k = 0; k < 12; k++) pat.push_back(1'b1);
    for (int k = 0; k < 10; k++) pat.push_back(1'b0);
    run_pattern(0);
  endtask

  task automatic test_op_wrap();
    int bn, vj;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      press(5'b00100, bn, vj);
      n_checks++;
      if (ALU_control !== m_op)
        $display("FAIL op_step %0d: got %0d expected %0d", k, ALU_control, m_op);
      else n_pass++;
    end
  endtask

  task automatic test_exec_err();
    int bn, vj;
    do_reset();
    sw = 16'($urandom);
    press(5'b00001, bn, vj);
    press(5'b01000, bn, vj);
    n_checks++;
    if (err !== 1'b1 || estado !== 2'd0 || bn != 0)
      $display("FAIL exec_no_b: got err=%b estado=%0d busy_n=%0d expected 1 0 0", err, estado, bn);
    else n_pass++;
    press(5'b00010, bn, vj);
    n_checks++;
    if (err !== m_err) $display("FAIL err_clear: got %b expected %b", err, m_err);
    else n_pass++;
    alu_fixed = 1; fix_res = 8'h41; fix_flags = 4'b0000;
    press(5'b01000, bn, vj);
    n_checks++;
    if (bn != ST) $display("FAIL busy_len: got %0d expected %0d", bn, ST);
    else n_pass++;
    n_checks++;
    if (vj != EFFECT_J + ST) $display("FAIL valid_latency: got %0d expected %0d", vj, EFFECT_J + ST);
    else n_pass++;
    n_checks++;
    if (result_out !== 8'h41 || flags_out !== 4'b0000 || result_valid !== 1'b1 || estado !== 2'd2)
      $display("FAIL exec_result: got %h %b %b %0d expected 41 0000 1 2",
               result_out, flags_out, result_valid, estado);
    else n_pass++;
    alu_fixed = 0;
  endtask

  task automatic test_same_edge();
    int bn, vj;
    sw = 16'($urandom);
    sw[7:0] = m_a ^ 8'($urandom_range(1, 255));
    press(5'b01001, bn, vj);
    n_checks++;
    if (num_a_out !== m_a) $display("FAIL same_edge_a: got %h expected %h", num_a_out, m_a);
    else n_pass++;
    n_checks++;
    if (result_out !== m_res || flags_out !== m_flags || estado !== 2'd2)
      $display("FAIL same_edge_res: got %h/%b/%0d expected %h/%b/2",
               result_out, flags_out, estado, m_res, m_flags);
    else n_pass++;
    press(5'b01100, bn, vj);
    n_checks++;
    if (ALU_control !== m_op || result_out !== m_res)
      $display("FAIL same_edge_op: got %0d/%h expected %0d/%h", ALU_control, result_out, m_op, m_res);
    else n_pass++;
  endtask

  task automatic test_random();
    int bn, vj;
    logic [4:0] mask;
    press(5'b10000, bn, vj);
    n_checks++;
    if (all_outs !== 37'h0) $display("FAIL clear_show: got %h expected 0", all_outs);
    else n_pass++;
    for (int it = 0; it < 12; it++) begin
      mask = 5'($urandom_range(0, 15));
      sw = 16'($urandom);
      press(mask, bn, vj);
      n_checks++;
      if (num_a_out !== m_a || num_b_out !== m_b || ALU_control !== m_op)
        $display("FAIL rand%0d_ops: got %h %h %0d expected %h %h %0d",
                 it, num_a_out, num_b_out, ALU_control, m_a, m_b, m_op);
      else n_pass++;
      n_checks++;
      if (result_out !== m_res || flags_out !== m_flags || result_valid !== m_valid)
        $display("FAIL rand%0d_res: got %h %b %b expected %h %b %b",
                 it, result_out, flags_out, result_valid, m_res, m_flags, m_valid);
      else n_pass++;
      n_checks++;
      if (err !== m_err || estado !== m_state || bn != (m_exec ? ST : 0))
        $display("FAIL rand%0d_ctl: got err=%b st=%0d busy_n=%0d expected %b %0d %0d",
                 it, err, estado, bn, m_err, m_state, m_exec ? ST : 0);
      else n_pass++;
    end
  endtask

  task automatic test_clear_exec();
    int bn, vj;
    bit saw_valid;
    sw = 16'($urandom);
    press(5'b00011, bn, vj);
    push = 5'b01000;
    @(negedge clk);
    push = 5'b11000;
    saw_valid = 0;
    for (int j = 2; j <= 22; j++) begin
      if (j == 9)  push[3] = 1'b0;
      if (j == 10) push[4] = 1'b0;
      @(negedge clk);
      if (j == 8) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL clear_in_exec_busy: got %b expected 1", busy);
        else n_pass++;
      end
      if (j == 9) begin
        n_checks++;
        if (all_outs !== 37'h0) $display("FAIL clear_exec_outs: got %h expected 0", all_outs);
        else n_pass++;
      end
      if (j >= 8 && result_valid) saw_valid = 1;
    end
    n_checks++;
    if (saw_valid) $display("FAIL clear_exec_valid: got 1 expected 0");
    else n_pass++;
    model_apply(5'b10000, sw);
  endtask

  task automatic test_rst_exec();
    int bn, vj;
    bit bad;
    sw = 16'($urandom);
    press(5'b00011, bn, vj);
    push = 5'b01000;
    repeat (EFFECT_J) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_in_exec_busy: got %b expected 1", busy);
    else n_pass++;
    rst = 1; push = '0;
    @(negedge clk);
    n_checks++;
    if (all_outs !== 37'h0) $display("FAIL rst_exec_outs: got %h expected 0", all_outs);
    else n_pass++;
    rst = 0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || estado !== 2'd0) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_exec_after: got capture or state change expected idle");
    else n_pass++;
    model_reset();
  endtask

  initial begin
    rst = 1; push = '0; sw = '0;
    alu_fixed = 0; fix_res = '0; fix_flags = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_ab();
    test_bounce();
    test_op_wrap();
    test_exec_err();
    test_same_edge();
    test_random();
    test_clear_exec();
    test_rst_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
